traffic_light: RTL and testbench
================================

// Module: traffic_light
// PURPOSE
// - Single-intersection traffic-light controller: cycles RED -> GREEN -> YELLOW -> RED with per-state dwell times.
// - State is exported as traffic_light_t from traffic_light_pkg (2-bit enum: RED=2'b00, YELLOW=2'b01, GREEN=2'b10; 2'b11 illegal).
// - Leaf block driving lamp decode and an optional pedestrian-request path; standalone with only clk/reset connected.
// PARAMETERS
// - RED_CYCLES        8   clocks spent in RED (>=1)
// - GREEN_CYCLES      6   clocks spent in GREEN (>=1)
// - YELLOW_CYCLES     2   clocks spent in YELLOW (>=1)
// - MIN_GREEN_CYCLES  2   minimum GREEN clocks before a pedestrian request may end GREEN (1..GREEN_CYCLES)
// - CNT_W             8   dwell counter width; every *_CYCLES must be <= 2**CNT_W
// PORTS
// - clk           in   1  rising-edge clock
// - asyn_n_reset  in   1  asynchronous, active-low reset
// - enable        in   1  1 = advance timing; 0 = freeze state and counter (default-tie 1'b1)
// - ped_req       in   1  pedestrian request pulse/level (default-tie 1'b0)
// - light_o       out  2  current state, type traffic_light_t
// - red_o         out  1  high iff light_o == RED
// - yellow_o      out  1  high iff light_o == YELLOW
// - green_o       out  1  high iff light_o == GREEN
// - walk_o        out  1  pedestrian walk lamp
// - state_chg_o   out  1  one-cycle pulse in the first cycle of each new state
// BEHAVIOUR
// - Reset (asyn_n_reset=0, async assert, sync release): state=RED, cnt=0, ped_pending=0, state_chg_o=0, walk_o=0.
// - Registered state and cnt; lamp outputs are combinational decode of state, exactly one high.
// - Per enabled clock: if cnt == DUR(state)-1 -> next state, cnt=0, state_chg_o=1; else cnt++, state_chg_o=0.
// - Transitions: RED->GREEN, GREEN->YELLOW, YELLOW->RED. After reset release RED lasts RED_CYCLES enabled clocks.
// - enable=0: state, cnt, ped_pending hold; state_chg_o=0. ped_req still latched (pedestrian feature only).
// - Illegal state 2'b11 (SEU/forced): next clock goes to RED, cnt=0, state_chg_o=1; lamps all 0 while illegal.
// - Counter never exceeds DUR-1; no wrap beyond CNT_W.
// - Reset mid-state: immediate RED, cnt=0, pending request dropped.
// CONFIGURATION
// - Macro TRAFFIC_LIGHT_PED_EN.
// - Defined: ped_req high on any clock sets ped_pending. In GREEN with ped_pending=1 and cnt >= MIN_GREEN_CYCLES-1,
//   next enabled clock goes to YELLOW (early exit). ped_pending clears on entry to RED. walk_o = (state==RED).
//   Request during RED is held and applies in the next GREEN. Simultaneous natural expiry and request: single YELLOW transition.
// - Not defined: ped_req ignored, ped_pending constant 0, walk_o tied 0; timing purely parameter-driven.
// TESTING
// - Reset 8 ns low pulse, defaults -> light_o=RED, red_o=1, walk_o=0; GREEN after 8 clocks, YELLOW 6 later, RED 2 later (16-clock period).
// - state_chg_o checked: exactly one pulse per transition, 3 pulses per 16-clock cycle, none during reset.
// - enable=0 for 5 clocks mid-GREEN at cnt=3 -> GREEN held, resumes and exits after 2 more enabled clocks.
// - Force state to 2'b11 -> lamps all 0 that cycle, RED with state_chg_o=1 next clock.
// - PED_EN: ped_req pulse at GREEN cnt=0 -> YELLOW after 2 GREEN clocks; ped_req in RED -> next GREEN shortened to 2; without macro GREEN stays 6.
// - Reset asserted mid-YELLOW -> RED immediately (async), cnt restarts, pending request cleared.

Source files
------------

// File: rtl/traffic_light.sv
// Single-intersection traffic-light controller: RED -> GREEN -> YELLOW -> RED with per-state dwell times.
// Define TRAFFIC_LIGHT_PED_EN to enable the pedestrian-request early exit from GREEN and the walk lamp.

package traffic_light_pkg;
    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } traffic_light_t;
endpackage

module traffic_light
    import traffic_light_pkg::*;
#(
    parameter int unsigned RED_CYCLES       = 8,
    parameter int unsigned GREEN_CYCLES     = 6,
    parameter int unsigned YELLOW_CYCLES    = 2,
    parameter int unsigned MIN_GREEN_CYCLES = 2,
    parameter int unsigned CNT_W            = 8
) (
    input  logic           clk,
    input  logic           asyn_n_reset,
    input  logic           enable,
    input  logic           ped_req,
    output traffic_light_t light_o,
    output logic           red_o,
    output logic           yellow_o,
    output logic           green_o,
    output logic           walk_o,
    output logic           state_chg_o
);

    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

    traffic_light_t   r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_state_chg;

    traffic_light_t   w_state_next;
    traffic_light_t   w_state_succ;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_dur_last;
    logic             w_chg_next;
    logic             w_illegal;
    logic             w_ped_exit;

    // Per-state dwell limit and successor; 2'b11 is flagged for recovery.
    always_comb begin
        w_dur_last   = RED_LAST;
        w_state_succ = GREEN;
        w_illegal    = 1'b0;
        case (r_state)
            RED: begin
                w_dur_last   = RED_LAST;
                w_state_succ = GREEN;
            end
            GREEN: begin
                w_dur_last   = GREEN_LAST;
                w_state_succ = YELLOW;
            end
            YELLOW: begin
                w_dur_last   = YELLOW_LAST;
                w_state_succ = RED;
            end
            default: begin
                w_dur_last   = '0;
                w_state_succ = RED;
                w_illegal    = 1'b1;
            end
        endcase
    end

    // Illegal-state recovery ignores enable so a corrupted state never lingers.
    // The >= compare also pulls an upset counter back to a clean boundary.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_chg_next   = 1'b0;
        if (w_illegal) begin
            w_state_next = RED;
            w_cnt_next   = '0;
            w_chg_next   = 1'b1;
        end else if (enable) begin
            if ((r_cnt >= w_dur_last) || w_ped_exit) begin
                w_state_next = w_state_succ;
                w_cnt_next   = '0;
                w_chg_next   = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge asyn_n_reset) begin
        if (!asyn_n_reset) begin
            r_state     <= RED;
            r_cnt       <= '0;
            r_state_chg <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_state_chg <= w_chg_next;
        end
    end

`ifdef TRAFFIC_LIGHT_PED_EN
    localparam logic [CNT_W-1:0] MIN_GREEN_LAST = CNT_W'(MIN_GREEN_CYCLES - 1);

    logic r_ped_pending;
    logic r_walk_arm;
    logic w_ped_pending_next;

    assign w_ped_exit = (r_state == GREEN) && r_ped_pending && (r_cnt >= MIN_GREEN_LAST);

    // A request arriving on the same clock that enters RED survives to the next GREEN.
    assign w_ped_pending_next = ped_req ||
                                (r_ped_pending && !(w_chg_next && (w_state_next == RED)));

    always_ff @(posedge clk or negedge asyn_n_reset) begin
        if (!asyn_n_reset) begin
            r_ped_pending <= 1'b0;
            r_walk_arm    <= 1'b0;
        end else begin
            r_ped_pending <= w_ped_pending_next;
            r_walk_arm    <= 1'b1;
        end
    end

    // Walk lamp stays dark while reset is held and lights with RED thereafter.
    assign walk_o = r_walk_arm && (r_state == RED);
`else
    localparam int unsigned UNUSED_MIN_GREEN = MIN_GREEN_CYCLES;

    logic w_unused_ped;

    assign w_unused_ped = ped_req;
    assign w_ped_exit   = 1'b0;
    assign walk_o       = 1'b0;
`endif

    assign light_o     = r_state;
    assign red_o       = (r_state == RED);
    assign yellow_o    = (r_state == YELLOW);
    assign green_o     = (r_state == GREEN);
    assign state_chg_o = r_state_chg;

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light: default timing, enable freeze, pedestrian request,
// illegal-state recovery and asynchronous reset mid-YELLOW.

module tb_traffic_light;
    import traffic_light_pkg::*;

`ifdef TRAFFIC_LIGHT_PED_EN
    localparam bit PED       = 1'b1;
    localparam int GREEN_PED = 2;
`else
    localparam bit PED       = 1'b0;
    localparam int GREEN_PED = 6;
`endif

    logic           clk = 1'b0;
    logic           asyn_n_reset;
    logic           enable;
    logic           ped_req;
    traffic_light_t light_o;
    logic           red_o;
    logic           yellow_o;
    logic           green_o;
    logic           walk_o;
    logic           state_chg_o;

    int n_checks = 0;
    int n_pass   = 0;
    int chg_seen = 0;

    always #5 clk = ~clk;

    traffic_light dut (
        .clk          (clk),
        .asyn_n_reset (asyn_n_reset),
        .enable       (enable),
        .ped_req      (ped_req),
        .light_o      (light_o),
        .red_o        (red_o),
        .yellow_o     (yellow_o),
        .green_o      (green_o),
        .walk_o       (walk_o),
        .state_chg_o  (state_chg_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag, input traffic_light_t exp, input logic exp_chg);
        logic exp_walk;
        exp_walk = PED && (exp == RED);
        chk({tag, "/light"}, 8'(light_o), 8'(exp));
        chk({tag, "/lamps"}, {4'b0, red_o, yellow_o, green_o, walk_o},
            {4'b0, exp == RED, exp == YELLOW, exp == GREEN, exp_walk});
        chk({tag, "/chg"}, {7'b0, state_chg_o}, {7'b0, exp_chg});
        if (state_chg_o) chg_seen++;
        $display("t=%0t %s light=%0d lamps=%b%b%b walk=%b chg=%b", $time, tag,
                 light_o, red_o, yellow_o, green_o, walk_o, state_chg_o);
    endtask

    task automatic run(input string tag, input traffic_light_t exp, input int n, input logic first_chg);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_state(tag, exp, first_chg && (i == 0));
        end
    endtask

    task automatic chk_reset_raw(input string tag);
        chk({tag, "/light"}, 8'(light_o), 8'(RED));
        chk({tag, "/lamps"}, {4'b0, red_o, yellow_o, green_o, walk_o}, 8'h08);
        chk({tag, "/chg"}, {7'b0, state_chg_o}, 8'h00);
        $display("t=%0t %s light=%0d walk=%b chg=%b", $time, tag, light_o, walk_o, state_chg_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        asyn_n_reset = 1'b0;
        enable       = 1'b1;
        ped_req      = 1'b0;
        #2;
        chk_reset_raw("reset");
        #6;
        asyn_n_reset = 1'b1;
        @(negedge clk);
        chk_reset_raw("release");

        // One full 16-clock period with three transition pulses.
        chg_seen = 0;
        run("p1_red", RED, 7, 1'b0);
        run("p1_green", GREEN, 6, 1'b1);
        run("p1_yellow", YELLOW, 2, 1'b1);
        run("p1_red_again", RED, 1, 1'b1);
        chk("p1_pulses", 8'(chg_seen), 8'd3);

        // Freeze for 5 clocks with GREEN at cnt=3.
        run("en_red", RED, 7, 1'b0);
        run("en_green", GREEN, 4, 1'b1);
        enable = 1'b0;
        run("en_hold", GREEN, 5, 1'b0);
        enable = 1'b1;
        run("en_resume", GREEN, 2, 1'b0);
        run("en_yellow", YELLOW, 2, 1'b1);
        run("en_red_again", RED, 1, 1'b1);

        // Pedestrian request raised during RED.
        ped_req = 1'b1;
        run("pa_red_req", RED, 1, 1'b0);
        ped_req = 1'b0;
        run("pa_red", RED, 6, 1'b0);
        run("pa_green", GREEN, GREEN_PED, 1'b1);
        run("pa_yellow", YELLOW, 2, 1'b1);
        run("pa_red_again", RED, 1, 1'b1);

        // Pedestrian pulse at GREEN cnt=0.
        run("pb_red", RED, 7, 1'b0);
        run("pb_green0", GREEN, 1, 1'b1);
        ped_req = 1'b1;
        run("pb_green1", GREEN, 1, 1'b0);
        ped_req = 1'b0;
        run("pb_green_rest", GREEN, GREEN_PED - 2, 1'b0);
        run("pb_yellow", YELLOW, 2, 1'b1);
        run("pb_red_again", RED, 1, 1'b1);

        // Illegal state recovery.
        force dut.r_state = traffic_light_t'(2'b11);
        #1;
        chk("ill/light", 8'(light_o), 8'h03);
        chk("ill/lamps", {4'b0, red_o, yellow_o, green_o, walk_o}, 8'h00);
        $display("t=%0t illegal light=%0d lamps=%b%b%b", $time, light_o, red_o, yellow_o, green_o);
        release dut.r_state;
        run("ill_recover", RED, 1, 1'b1);
        run("ill_red", RED, 7, 1'b0);
        run("ill_green", GREEN, 6, 1'b1);
        run("ill_yellow0", YELLOW, 1, 1'b1);

        // Latch a request in YELLOW, then reset mid-YELLOW: request must be dropped.
        ped_req = 1'b1;
        run("rst_yellow1", YELLOW, 1, 1'b0);
        ped_req = 1'b0;
        #2;
        asyn_n_reset = 1'b0;
        #1;
        chk_reset_raw("rst_async");
        @(negedge clk);
        chk_reset_raw("rst_held");
        #3;
        asyn_n_reset = 1'b1;
        run("rst_red", RED, 7, 1'b0);
        run("rst_green", GREEN, 6, 1'b1);
        run("rst_yellow", YELLOW, 2, 1'b1);
        run("rst_red_again", RED, 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
